// File: rtl/lpddr5_pkg.sv
// Shared types and constants for the LPDDR5 memory arbiter.
package lpddr5_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 64;

  // Write enable is held for this many cycles so the memory latches on its
  // second falling edge.
  localparam int unsigned WR_HOLD_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WR1,
    WR2,
    RD,
    RD_CAP,
    PD,
    WAKE
  } arb_state_e;

endpackage

// File: rtl/lpddr5_rr_arbiter.sv
// Combinational round-robin select: first valid requester at or after ptr_i.
module lpddr5_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters in rotated order starting at the pointer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && valid_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lpddr5_mem_arbiter.sv
// LPDDR5 memory access sequencer with round-robin sharing and power-down.
// Optional per-requester grant and power-down cycle counters are built when
// LPDDR5_ARB_PERF_CNT_EN is defined.
module lpddr5_mem_arbiter
  import lpddr5_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned WAKE_CYCLES  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_clk_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data
`ifdef LPDDR5_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_grants,
  output logic [31:0]                   perf_pd_cycles
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned IC_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned WC_W  = $clog2(WAKE_CYCLES + 1);

  arb_state_e            state_q;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [IC_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [WC_W-1:0]       wake_cnt_q;

  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  mem_clk_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q;
  logic                  mem_wr_en_q;
  logic                  mem_rd_en_q;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_we;

  lpddr5_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign win_addr  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_we    = req_we[arb_idx];

  // Acceptance is only offered while idle; the grant is already one-hot.
  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;

  // Next pointer after the winner and the saturating idle count.
  always_comb begin
    ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    idle_cnt_d = (idle_cnt_q == IC_W'(IDLE_TIMEOUT)) ? idle_cnt_q
                                                      : idle_cnt_q + 1'b1;
  end

  // Access sequencer, power management and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      mem_clk_en_q  <= 1'b1;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            gnt_q         <= arb_gnt;
            ptr_q         <= ptr_d;
            idle_cnt_q    <= '0;
            mem_addr_q    <= win_addr;
            mem_wr_data_q <= win_wdata;
            if (win_we) begin
              mem_wr_en_q <= 1'b1;
              state_q     <= WR1;
            end else begin
              mem_rd_en_q <= 1'b1;
              state_q     <= RD;
            end
          end else begin
            idle_cnt_q <= idle_cnt_d;
            if (idle_cnt_d == IC_W'(IDLE_TIMEOUT)) begin
              mem_clk_en_q <= 1'b0;
              state_q      <= PD;
            end
          end
        end
        WR1: state_q <= WR2;
        WR2: begin
          mem_wr_en_q <= 1'b0;
          rsp_valid_q <= gnt_q;
          state_q     <= IDLE;
        end
        RD: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= RD_CAP;
        end
        RD_CAP: begin
          rsp_rdata_q <= mem_rd_data;
          rsp_valid_q <= gnt_q;
          state_q     <= IDLE;
        end
        PD: begin
          if (|req_valid) begin
            mem_clk_en_q <= 1'b1;
            wake_cnt_q   <= '0;
            // Start the next idle window fresh rather than at saturation.
            idle_cnt_q   <= '0;
            state_q      <= WAKE;
          end
        end
        WAKE: begin
          if (wake_cnt_q == WC_W'(WAKE_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_clk_en  = mem_clk_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;

`ifdef LPDDR5_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0] hs;
  logic [31:0]        pd_cnt_q;

  assign hs = req_valid & req_ready;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [31:0] cnt_q;
    // Wrapping count of accepted requests for this requester.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (hs[gi]) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign perf_grants[gi*32 +: 32] = cnt_q;
  end

  // Cycles spent with the memory clock disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_cnt_q <= '0;
    end else if (state_q == PD) begin
      pd_cnt_q <= pd_cnt_q + 32'd1;
    end
  end
  assign perf_pd_cycles = pd_cnt_q;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_lpddr5_mem_arbiter.sv
// Scoreboard bench for lpddr5_mem_arbiter (LPDDR5_ARB_PERF_CNT_EN optional).
module tb_lpddr5_mem_arbiter;
  import lpddr5_pkg::*;

  localparam int unsigned NR      = 2;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 64;
  localparam int unsigned IDLE_TO = 16;
  localparam int unsigned WAKE_C  = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic          v_r  [NR];
  logic          we_r [NR];
  logic [AW-1:0] a_r  [NR];
  logic [DW-1:0] d_r  [NR];

  logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, mem_wr_data, mem_rd_data;
  logic [AW-1:0]    mem_addr;
  logic             mem_clk_en, mem_wr_en, mem_rd_en;
`ifdef LPDDR5_ARB_PERF_CNT_EN
  logic [NR*32-1:0] perf_grants;
  logic [31:0]      perf_pd_cycles;
`endif

  assign req_valid = {v_r[1], v_r[0]};
  assign req_we    = {we_r[1], we_r[0]};
  assign req_addr  = {a_r[1], a_r[0]};
  assign req_wdata = {d_r[1], d_r[0]};

  lpddr5_mem_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .IDLE_TIMEOUT (IDLE_TO),
    .WAKE_CYCLES  (WAKE_C)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_clk_en  (mem_clk_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data)
`ifdef LPDDR5_ARB_PERF_CNT_EN
    ,
    .perf_grants    (perf_grants),
    .perf_pd_cycles (perf_pd_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: unwritten words read as {48'hC0FFEE000000, addr};
  // a write is stored on the falling edge of its second enable cycle.
  logic [DW-1:0] mem     [0:65535];
  bit            written [0:65535];
  int            wr_run = 0;

  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_data <= written[mem_addr] ? mem[mem_addr] : {48'hC0FFEE000000, mem_addr};
  end

  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_run + 1 == int'(WR_HOLD_CYCLES)) begin
        mem[mem_addr]     <= mem_wr_data;
        written[mem_addr] <= 1'b1;
      end
      wr_run <= wr_run + 1;
    end else begin
      if (wr_run != 0) check("wr_en_hold_len", wr_run, WR_HOLD_CYCLES);
      wr_run <= 0;
    end
    if (mem_wr_en || mem_rd_en) check("cmd_needs_clk_en", mem_clk_en, 1);
  end

  // Scoreboard of expected responses.
  typedef struct {
    int            req;
    bit            rd;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];
  int   grant_log[$];

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rsp_valid != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid_req", rsp_valid, NR'(1) << e.req);
        check("rsp_latency", cyc, e.due);
        if (e.rd) check("rsp_rdata", rsp_rdata, e.data);
      end
    end
    if (|req_ready) check("ready_onehot", $onehot(req_ready), 1);
    if (|(req_valid & req_ready)) grant_log.push_back(req_ready[1] ? 1 : 0);
  end

  task automatic do_req(input int r, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                        input bit expect_rsp, output int acc);
    bit   done = 1'b0;
    exp_t e;
    acc      = -1;
    v_r[r]   = 1'b1;
    we_r[r]  = we;
    a_r[r]   = addr;
    d_r[r]   = wdata;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        done = 1'b1;
        acc  = cyc;
        if (expect_rsp) begin
          e.req  = r;
          e.rd   = !we;
          e.data = exp_rd;
          e.due  = cyc + 3;
          sb.push_back(e);
        end
      end
    end
    check("grant_within_bound", done, 1);
    @(posedge clk);
    #1;
    v_r[r] = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready",   req_ready,   0);
    check("rst_rsp_valid",   rsp_valid,   0);
    check("rst_rsp_rdata",   rsp_rdata,   0);
    check("rst_mem_clk_en",  mem_clk_en,  1);
    check("rst_mem_addr",    mem_addr,    0);
    check("rst_mem_wr_data", mem_wr_data, 0);
    check("rst_mem_wr_en",   mem_wr_en,   0);
    check("rst_mem_rd_en",   mem_rd_en,   0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    check("drain_outstanding", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc, acc_w, acc_r, a0, a1;
    int exp_ord [6] = '{0, 1, 0, 1, 0, 1};
    bit seen;

    rst_n = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      v_r[i] = 1'b0; we_r[i] = 1'b0; a_r[i] = '0; d_r[i] = '0;
    end

    // Single write then read by requester 0.
    apply_reset();
    do_req(0, 1'b1, 16'h0010, 64'hDEADBEEF_CAFEF00D, '0, 1'b1, acc);
    do_req(0, 1'b0, 16'h0010, '0, 64'hDEADBEEF_CAFEF00D, 1'b1, acc);
    drain();

    // Contention: both requesters continuously valid, three reads each.
    apply_reset();
    grant_log.delete();
    fork
      begin
        int x;
        for (int k = 0; k < 3; k++) do_req(0, 1'b0, 16'h0010, '0, 64'hDEADBEEF_CAFEF00D, 1'b1, x);
      end
      begin
        int y;
        for (int k = 0; k < 3; k++) do_req(1, 1'b0, 16'h0020, '0, 64'hC0FFEE0000000020, 1'b1, y);
      end
    join
    drain();
    check("grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) check("grant_order", grant_log[i], exp_ord[i]);

    // Power-down after the idle timeout, then wake on a read from req1.
    apply_reset();
    for (int unsigned k = 1; k <= IDLE_TO; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("clk_en_idle_window", mem_clk_en, (k < IDLE_TO) ? 1 : 0);
    end
    fork
      do_req(1, 1'b0, 16'h0030, '0, 64'hC0FFEE0000000030, 1'b1, acc);
      begin
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
          @(negedge clk);
          seen = mem_clk_en;
        end
        check("wake_clk_en", seen, 1);
        for (int unsigned j = 0; j < WAKE_C; j++) begin
          if (j > 0) @(negedge clk);
          check("wake_no_rd_en", mem_rd_en, 0);
          check("wake_no_ready", req_ready, 0);
        end
      end
    join
    drain();

    // Read from req0 issued while req1's write is in flight.
    fork
      do_req(1, 1'b1, 16'h0001, 64'h1, '0, 1'b1, acc_w);
      begin
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          seen = req_valid[1] & req_ready[1];
        end
        @(posedge clk);
        #1;
        do_req(0, 1'b0, 16'h0001, '0, 64'h1, 1'b1, acc_r);
      end
    join
    check("rd_accept_after_wr", acc_r, acc_w + 3);
    drain();

    // Reset during WR1: outputs clear at once, no response, pointer back to 0.
    do_req(0, 1'b1, 16'h0040, 64'h5555AAAA5555AAAA, '0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      do_req(0, 1'b0, 16'h0040, '0, 64'hC0FFEE0000000040, 1'b1, a0);
      do_req(1, 1'b0, 16'h0001, '0, 64'h1, 1'b1, a1);
    join
    check("ptr_zero_after_reset", a0 < a1, 1);
    check("second_grant_spacing", a1, a0 + 3);
    drain();

`ifdef LPDDR5_ARB_PERF_CNT_EN
    apply_reset();
    for (int k = 0; k < 5; k++) do_req(0, 1'b0, 16'h0010, '0, 64'hDEADBEEF_CAFEF00D, 1'b1, acc);
    for (int k = 0; k < 3; k++) do_req(1, 1'b0, 16'h0020, '0, 64'hC0FFEE0000000020, 1'b1, acc);
    drain();
    check("perf_grants_req0", perf_grants[31:0], 5);
    check("perf_grants_req1", perf_grants[63:32], 3);
    repeat (IDLE_TO + 4) @(negedge clk);
    check("perf_pd_nonzero", perf_pd_cycles != 0, 1);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
